// File: rtl/ex_muldiv_pkg.sv
// Shared constants, types and helpers for the RV32M execute-stage mul/div unit.
// Holds the M-extension funct3/funct7 codes, FSM state encodings, the latched
// operation record and small result-selection helpers.
package ex_muldiv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 6;

  localparam logic [2:0] EXE_MUL_FUNCT3    = 3'b000;
  localparam logic [2:0] EXE_MULH_FUNCT3   = 3'b001;
  localparam logic [2:0] EXE_MULHSU_FUNCT3 = 3'b010;
  localparam logic [2:0] EXE_MULHU_FUNCT3  = 3'b011;
  localparam logic [2:0] EXE_DIV_FUNCT3    = 3'b100;
  localparam logic [2:0] EXE_DIVU_FUNCT3   = 3'b101;
  localparam logic [2:0] EXE_REM_FUNCT3    = 3'b110;
  localparam logic [2:0] EXE_REMU_FUNCT3   = 3'b111;

  localparam logic [6:0] EXE_MULDIV_FUNCT7 = 7'b0000001;

  localparam logic [XLEN-1:0] ZERO_WORD        = '0;
  localparam logic [XLEN-1:0] DIV_BY_ZERO_QUOT = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] INT_MIN_WORD     = 32'h8000_0000;
  localparam logic [4:0]      NOP_REG_ADDR     = 5'd0;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  // Operation record captured at start and held until the result is produced.
  typedef struct packed {
    logic [2:0] funct3;
    logic       neg_res;  // negate product / quotient
    logic       neg_rem;  // negate remainder (sign of rs1)
    logic [4:0] wd;
    logic       wreg;
  } md_op_t;

  // rs1 is treated as signed for MUL, MULH, MULHSU, DIV, REM.
  function automatic logic rs1_signed(input logic [2:0] f3);
    return f3[2] ? ~f3[0] : (f3[1:0] != 2'b11);
  endfunction

  // rs2 is treated as signed for MUL, MULH, DIV, REM.
  function automatic logic rs2_signed(input logic [2:0] f3);
    return f3[2] ? ~f3[0] : ~f3[1];
  endfunction

  // MUL returns the low word; the MULH variants return the high word.
  function automatic logic [XLEN-1:0] mul_select(input logic [2:0]        f3,
                                                 input logic [2*XLEN-1:0] prod);
    return (f3[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  endfunction

endpackage

// File: rtl/ex_muldiv_iter.sv
// Unsigned iterative datapath: shift-add multiply or restoring divide, one bit
// per step, XLEN steps per operation.
//   clk, rst      : clock, async active-high reset
//   load_i        : capture operands, mode, clear counter
//   div_i         : 1 = restoring divide, 0 = shift-add multiply
//   step_i        : perform one iteration this cycle
//   a_i, b_i      : multiplier/dividend and multiplicand/divisor magnitudes
//   acc_nxt_c_o   : accumulator value after this cycle's step (combinational)
//                   multiply: full product; divide: {remainder, quotient}
//   last_c_o      : this step is the final one (combinational)
module muldiv_iter
  import ex_muldiv_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load_i,
  input  logic                div_i,
  input  logic                step_i,
  input  logic [XLEN-1:0]     a_i,
  input  logic [XLEN-1:0]     b_i,
  output logic [2*XLEN-1:0]   acc_nxt_c_o,
  output logic                last_c_o
);

  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   b_q;
  logic              div_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [XLEN-1:0]   hi;
  logic [XLEN-1:0]   lo;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_sh;
  logic [XLEN:0]     rem_diff;
  logic [2*XLEN-1:0] mul_nxt;
  logic [2*XLEN-1:0] div_nxt;

  // One iteration of either algorithm on the current accumulator.
  always_comb begin
    hi       = acc_q[2*XLEN-1:XLEN];
    lo       = acc_q[XLEN-1:0];
    // Multiply: conditionally add multiplicand to upper half, then shift right.
    mul_sum  = {1'b0, hi} + ({1'b0, b_q} & {(XLEN+1){lo[0]}});
    mul_nxt  = {mul_sum, lo[XLEN-1:1]};
    // Divide: shift next dividend bit into remainder, try subtracting divisor.
    rem_sh   = {hi, lo[XLEN-1]};
    rem_diff = rem_sh - {1'b0, b_q};
    if (!rem_diff[XLEN]) begin
      div_nxt = {rem_diff[XLEN-1:0], lo[XLEN-2:0], 1'b1};
    end else begin
      div_nxt = {rem_sh[XLEN-1:0], lo[XLEN-2:0], 1'b0};
    end
    acc_nxt_c_o = div_q ? div_nxt : mul_nxt;
    last_c_o    = step_i && (cnt_q == CNT_W'(XLEN - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
    end else if (load_i) begin
      acc_q <= {XLEN'(0), a_i};
      b_q   <= b_i;
      div_q <= div_i;
      cnt_q <= '0;
    end else if (step_i) begin
      acc_q <= acc_nxt_c_o;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// Execute-stage RV32M multiply/divide unit. Latches the ID/EX operation on
// start, iterates in muldiv_iter, applies sign correction and produces a
// one-cycle result strobe while stalling the pipeline.
// Optional macro MULDIV_FAST_MUL_EN: multiplies complete in one cycle using a
// full-width product computed in IDLE; divides stay iterative.
//   clk, rst    : clock, async active-high reset
//   start_i     : M-extension op present in EX
//   funct3_i    : M op select
//   reg1_i/2_i  : rs1 / rs2 values
//   wd_i/wreg_i : destination address / write enable
//   annul_i     : pipeline flush
//   result_o    : result, valid while valid_o
//   wd_o        : latched destination address
//   wreg_o      : latched write enable qualified by valid_o
//   valid_o     : one-cycle result strobe
//   stallreq_o  : stall request (combinational)
module ex_muldiv
  import ex_muldiv_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       funct3_i,
  input  logic [XLEN-1:0]  reg1_i,
  input  logic [XLEN-1:0]  reg2_i,
  input  logic [4:0]       wd_i,
  input  logic             wreg_i,
  input  logic             annul_i,
  output logic [XLEN-1:0]  result_o,
  output logic [4:0]       wd_o,
  output logic             wreg_o,
  output logic             valid_o,
  output logic             stallreq_o
);

  md_state_e         state_q;
  md_op_t            op_q;
  logic [XLEN-1:0]   result_q;
  logic              valid_q;
  logic              wreg_q;

  logic              is_div;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic              div_zero;
  logic              div_ovf;
  logic              special;
  logic [XLEN-1:0]   special_res;
  logic              start_ok;
  logic              iter_load;
  logic              iter_step;
  logic [2*XLEN-1:0] acc_nxt;
  logic              iter_last;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   calc_res;

  // Operand signs, magnitudes and the divide special cases.
  always_comb begin
    is_div   = funct3_i[2];
    a_neg    = rs1_signed(funct3_i) & reg1_i[XLEN-1];
    b_neg    = rs2_signed(funct3_i) & reg2_i[XLEN-1];
    mag_a    = a_neg ? -reg1_i : reg1_i;
    mag_b    = b_neg ? -reg2_i : reg2_i;
    div_zero = is_div && (reg2_i == ZERO_WORD);
    div_ovf  = is_div && !funct3_i[0] && (reg1_i == INT_MIN_WORD) && (reg2_i == '1);
    special  = div_zero || div_ovf;
    // funct3[1] distinguishes REM/REMU from DIV/DIVU.
    if (div_zero) begin
      special_res = funct3_i[1] ? reg1_i : DIV_BY_ZERO_QUOT;
    end else begin
      special_res = funct3_i[1] ? ZERO_WORD : INT_MIN_WORD;
    end
    start_ok = (state_q == MD_IDLE) && start_i && !annul_i;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  logic [2*XLEN-1:0] fast_fix;

  // Single-cycle product on magnitudes, sign applied afterwards.
  always_comb begin
    fast_prod = (2*XLEN)'(mag_a) * (2*XLEN)'(mag_b);
    fast_fix  = (a_neg ^ b_neg) ? -fast_prod : fast_prod;
  end

  assign iter_load = start_ok && !special && is_div;
`else
  assign iter_load = start_ok && !special;
`endif

  assign iter_step = (state_q == MD_CALC) && !annul_i;

  muldiv_iter u_iter (
    .clk         (clk),
    .rst         (rst),
    .load_i      (iter_load),
    .div_i       (is_div),
    .step_i      (iter_step),
    .a_i         (mag_a),
    .b_i         (mag_b),
    .acc_nxt_c_o (acc_nxt),
    .last_c_o    (iter_last)
  );

  // Sign correction of the final iterative result.
  always_comb begin
    prod_fix = op_q.neg_res ? -acc_nxt : acc_nxt;
    quot_fix = op_q.neg_res ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
    rem_fix  = op_q.neg_rem ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
    if (op_q.funct3[2]) begin
      calc_res = op_q.funct3[1] ? rem_fix : quot_fix;
    end else begin
      calc_res = mul_select(op_q.funct3, prod_fix);
    end
  end

  // Control FSM with registered result, strobe and write enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= MD_IDLE;
      op_q     <= '0;
      result_q <= ZERO_WORD;
      valid_q  <= 1'b0;
      wreg_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      wreg_q  <= 1'b0;
      case (state_q)
        MD_IDLE: begin
          if (start_ok) begin
            op_q <= '{funct3:  funct3_i,
                      neg_res: a_neg ^ b_neg,
                      neg_rem: a_neg,
                      wd:      wd_i,
                      wreg:    wreg_i};
            if (special) begin
              result_q <= special_res;
              valid_q  <= 1'b1;
              wreg_q   <= wreg_i;
              state_q  <= MD_DONE;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (!is_div) begin
              result_q <= mul_select(funct3_i, fast_fix);
              valid_q  <= 1'b1;
              wreg_q   <= wreg_i;
              state_q  <= MD_DONE;
            end
`endif
            else begin
              state_q <= MD_CALC;
            end
          end
        end
        MD_CALC: begin
          if (annul_i) begin
            state_q <= MD_IDLE;
          end else if (iter_last) begin
            result_q <= calc_res;
            valid_q  <= 1'b1;
            wreg_q   <= op_q.wreg;
            state_q  <= MD_DONE;
          end
        end
        MD_DONE: begin
          state_q <= MD_IDLE;
        end
        default: begin
          state_q <= MD_IDLE;
        end
      endcase
    end
  end

  // A flush in the result cycle suppresses the strobe and the write.
  assign result_o   = result_q;
  assign wd_o       = op_q.wd;
  assign valid_o    = valid_q && !annul_i;
  assign wreg_o     = wreg_q && !annul_i;
  assign stallreq_o = start_ok || (state_q == MD_CALC);

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed RV32M cases plus randomized ops
// checked against an arithmetic reference model, with flush and reset cases.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [2:0]  funct3_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic        annul_i;
  logic [31:0] result_o;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic        valid_o;
  logic        stallreq_o;

  int n_cmp = 0;
  int n_bad = 0;

  ex_muldiv dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .funct3_i   (funct3_i),
    .reg1_i     (reg1_i),
    .reg2_i     (reg2_i),
    .wd_i       (wd_i),
    .wreg_i     (wreg_i),
    .annul_i    (annul_i),
    .result_o   (result_o),
    .wd_o       (wd_o),
    .wreg_o     (wreg_o),
    .valid_o    (valid_o),
    .stallreq_o (stallreq_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // RV32M semantics computed with 64-bit host arithmetic.
  function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint          ubs;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'h0, a};
    ub  = {32'h0, b};
    ubs = longint'(ub);
    p   = '0;
    case (f3)
      3'd0: begin p = sa * sb;  return p[31:0];  end
      3'd1: begin p = sa * sb;  return p[63:32]; end
      3'd2: begin p = sa * ubs; return p[63:32]; end
      3'd3: begin p = ua * ub;  return p[63:32]; end
      3'd4: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 32'h0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'h0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b);
    if (f3[2] && b == 32'h0) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!f3[2]) return 1;
`endif
    return 33;
  endfunction

  // Issue one op (entered #1 after a rising edge) and check the whole handshake.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] wd, input logic wr);
    int   lat;
    logic seen;
    logic stall_ok;
    funct3_i = f3; reg1_i = a; reg2_i = b; wd_i = wd; wreg_i = wr; start_i = 1'b1;
    #1;
    stall_ok = stallreq_o;
    lat      = 0;
    seen     = 1'b0;
    while (lat < 40 && !seen) begin
      @(posedge clk); #1;
      lat++;
      if (valid_o) seen = 1'b1;
      else if (!stallreq_o) stall_ok = 1'b0;
    end
    start_i = 1'b0;
    check($sformatf("%s/latency", tag), 64'(lat), 64'(ref_lat(f3, a, b)));
    check($sformatf("%s/stall", tag), {63'h0, stall_ok}, 64'h1);
    check($sformatf("%s/result", tag), {32'h0, result_o}, {32'h0, ref_res(f3, a, b)});
    check($sformatf("%s/wreg", tag), {63'h0, wreg_o}, {63'h0, wr});
    check($sformatf("%s/wd", tag), {59'h0, wd_o}, {59'h0, wd});
    check($sformatf("%s/done_stall", tag), {63'h0, stallreq_o}, 64'h0);
    @(posedge clk); #1;
    check($sformatf("%s/valid_pulse", tag), {63'h0, valid_o}, 64'h0);
  endtask

  // Watch for any result strobe over a window of cycles.
  task automatic expect_quiet(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (valid_o || wreg_o) seen = 1'b1;
    end
    check(tag, {63'h0, seen}, 64'h0);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1; start_i = 1'b0; funct3_i = 3'd0; reg1_i = '0; reg2_i = '0;
    wd_i = '0; wreg_i = 1'b0; annul_i = 1'b0;
    #12;
    check("reset/result", {32'h0, result_o}, 64'h0);
    check("reset/wd", {59'h0, wd_o}, 64'h0);
    check("reset/wreg", {63'h0, wreg_o}, 64'h0);
    check("reset/valid", {63'h0, valid_o}, 64'h0);
    check("reset/stall", {63'h0, stallreq_o}, 64'h0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    run_op("mul_7x-3",   3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd9,  1'b1);
    run_op("mulhu_ff",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 1'b1);
    run_op("mulh_ff",    3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 1'b1);
    run_op("mulhsu",     3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5'd12, 1'b1);
    run_op("div_-7_2",   3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd13, 1'b1);
    run_op("rem_-7_2",   3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd14, 1'b1);
    run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 5'd15, 1'b1);
    run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 5'd16, 1'b0);
    run_op("div_by0",    3'd4, 32'd5, 32'd0, 5'd17, 1'b1);
    run_op("rem_by0",    3'd6, 32'd5, 32'd0, 5'd18, 1'b1);
    run_op("div_ovf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 1'b1);
    run_op("rem_ovf",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 1'b1);
    run_op("mul_123x456", 3'd0, 32'd123, 32'd456, 5'd21, 1'b1);

    // Flush in the same cycle as start: the op must be dropped.
    funct3_i = 3'd5; reg1_i = 32'd1000; reg2_i = 32'd3; wd_i = 5'd3; wreg_i = 1'b1;
    start_i = 1'b1; annul_i = 1'b1;
    #1;
    check("annul_start/stall", {63'h0, stallreq_o}, 64'h0);
    @(posedge clk); #1;
    start_i = 1'b0; annul_i = 1'b0;
    #1;
    check("annul_start/idle", {63'h0, stallreq_o}, 64'h0);
    expect_quiet("annul_start/no_valid", 40);

    // Flush at T+10 of a DIVU.
    funct3_i = 3'd5; reg1_i = 32'd1000; reg2_i = 32'd3; wd_i = 5'd4; wreg_i = 1'b1;
    start_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
    end
    check("annul_mid/stall_before", {63'h0, stallreq_o}, 64'h1);
    annul_i = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;
    annul_i = 1'b0;
    #1;
    check("annul_mid/stall_dropped", {63'h0, stallreq_o}, 64'h0);
    expect_quiet("annul_mid/no_valid", 40);
    run_op("after_annul", 3'd5, 32'd1000, 32'd3, 5'd6, 1'b1);

    for (int n = 0; n < 40; n++) begin
      run_op($sformatf("rnd%0d", n), 3'($urandom_range(0, 7)), rnd_operand(), rnd_operand(),
             5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset at T+5 of a MUL.
    funct3_i = 3'd0; reg1_i = 32'd7; reg2_i = 32'hFFFF_FFFD; wd_i = 5'd25; wreg_i = 1'b1;
    start_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1; start_i = 1'b0;
    #1;
    check("midrst/result", {32'h0, result_o}, 64'h0);
    check("midrst/wd", {59'h0, wd_o}, 64'h0);
    check("midrst/wreg", {63'h0, wreg_o}, 64'h0);
    check("midrst/valid", {63'h0, valid_o}, 64'h0);
    check("midrst/stall", {63'h0, stallreq_o}, 64'h0);
    @(negedge clk); rst = 1'b0;
    expect_quiet("midrst/no_valid", 40);
    run_op("after_rst", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd26, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
